// File: rtl/ofdm_cp_remover_pkg.sv
// Shared definitions for the OFDM cyclic-prefix remover: the framing state
// encoding, error-bit positions and a saturating counter helper.
package ofdm_pkg;

  // Framing states of the CP remover
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a start-of-packet
    ST_CP    = 2'd1,  // discarding cyclic-prefix samples
    ST_BODY  = 2'd2,  // forwarding useful samples
    ST_FLUSH = 2'd3   // discarding the tail of an over-long packet
  } state_e;

  // Bit positions inside aso_out0_error
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;

  // Error code values presented with an output endofpacket
  localparam logic [1:0] ERR_CODE_NONE  = 2'b00;
  localparam logic [1:0] ERR_CODE_SHORT = 2'b01;
  localparam logic [1:0] ERR_CODE_LONG  = 2'b10;

  // Increment a 16-bit counter, sticking at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover (Avalon-ST in / out).
// Each input packet is CP_LEN prefix samples followed by FFT_LEN useful
// samples. The prefix is dropped and the useful part is forwarded through a
// single registered output stage, with framing errors flagged on the output
// endofpacket beat.
// Optional statistics counters are compiled in when OFDM_CP_REMOVER_STATS_EN
// is defined.
module ofdm_cp_remover
  import ofdm_pkg::*;
#(
  parameter int DATA_W  = 22,
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  input  logic              asi_in0_startofpacket,
  input  logic              asi_in0_endofpacket,
  output logic              asi_in0_ready,
  output logic [DATA_W-1:0] aso_out0_data,
  output logic              aso_out0_valid,
  output logic              aso_out0_startofpacket,
  output logic              aso_out0_endofpacket,
  output logic [1:0]        aso_out0_error,
  input  logic              aso_out0_ready
`ifdef OFDM_CP_REMOVER_STATS_EN
  ,
  output logic [31:0]       stat_symbols,
  output logic [15:0]       stat_errors
`endif
);

  localparam int CNT_W = $clog2(FFT_LEN);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN);
  localparam logic [CNT_W-1:0] BODY_LAST = CNT_W'(FFT_LEN - 1);

  // Framing state and the shared sample counter
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output register stage
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              sop_q;
  logic              eop_q;
  logic [1:0]        err_q;

  // Decoded per-sample actions
  logic       in_ready_s;
  logic       in_acc_s;
  logic       fwd_s;
  logic       fwd_sop_s;
  logic       fwd_eop_s;
  logic [1:0] fwd_err_s;

  // The single output stage can take a new beat when empty or draining
  assign in_ready_s    = !valid_q || aso_out0_ready;
  assign in_acc_s      = asi_in0_valid && in_ready_s;
  assign asi_in0_ready = in_ready_s;

  assign aso_out0_data          = data_q;
  assign aso_out0_valid         = valid_q;
  assign aso_out0_startofpacket = sop_q;
  assign aso_out0_endofpacket   = eop_q;
  assign aso_out0_error         = err_q;

  // Next-state, counter and forward decision for the accepted sample
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fwd_s     = 1'b0;
    fwd_sop_s = 1'b0;
    fwd_eop_s = 1'b0;
    fwd_err_s = ERR_CODE_NONE;

    if (!in_acc_s) begin
      state_d = state_q;
    end else if (asi_in0_startofpacket) begin
      // A start-of-packet always restarts framing, whatever the state.
      // An aborted output symbol is left without an endofpacket.
      if (asi_in0_endofpacket) begin
        // One-sample packet: ends inside the prefix, nothing forwarded
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end else if (CP_LEN == 1) begin
        state_d = ST_BODY;
        cnt_d   = CNT_ZERO;
      end else begin
        state_d = ST_CP;
        cnt_d   = CNT_ONE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Samples outside a packet are discarded
          state_d = ST_IDLE;
        end
        ST_CP: begin
          if (asi_in0_endofpacket) begin
            // Packet ended inside its prefix: drop it entirely
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if ((cnt_q + CNT_ONE) == CP_LAST) begin
            state_d = ST_BODY;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_BODY: begin
          fwd_s     = 1'b1;
          fwd_sop_s = (cnt_q == CNT_ZERO);
          if (cnt_q == BODY_LAST) begin
            // Last useful sample: the output symbol always closes here
            fwd_eop_s = 1'b1;
            cnt_d     = CNT_ZERO;
            if (asi_in0_endofpacket) begin
              state_d = ST_IDLE;
            end else begin
              fwd_err_s[ERR_LONG] = 1'b1;
              state_d             = ST_FLUSH;
            end
          end else if (asi_in0_endofpacket) begin
            fwd_eop_s            = 1'b1;
            fwd_err_s[ERR_SHORT] = 1'b1;
            state_d              = ST_IDLE;
            cnt_d                = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_FLUSH: begin
          // Discard the excess tail until the input packet closes
          if (asi_in0_endofpacket) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Framing state and counter registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register stage: loads whenever the stage can accept, holds on stall
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= ERR_CODE_NONE;
    end else if (in_ready_s) begin
      valid_q <= fwd_s;
      sop_q   <= fwd_sop_s;
      eop_q   <= fwd_eop_s;
      err_q   <= fwd_err_s;
      if (fwd_s) begin
        data_q <= asi_in0_data;
      end else begin
        data_q <= data_q;
      end
    end else begin
      data_q  <= data_q;
      valid_q <= valid_q;
      sop_q   <= sop_q;
      eop_q   <= eop_q;
      err_q   <= err_q;
    end
  end

`ifdef OFDM_CP_REMOVER_STATS_EN
  logic [31:0] symbols_q;
  logic [15:0] errors_q;
  logic        good_evt_s;
  logic        err_evt_s;
  logic        cp_drop_s;

  // A packet ending while still in its prefix (including one-sample packets)
  assign cp_drop_s  = in_acc_s && asi_in0_endofpacket &&
                      (asi_in0_startofpacket || (state_q == ST_CP));
  assign good_evt_s = fwd_s && fwd_eop_s && (fwd_err_s == ERR_CODE_NONE);
  assign err_evt_s  = (fwd_s && (fwd_err_s != ERR_CODE_NONE)) || cp_drop_s;

  // Good-symbol and framing-error event counters
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      symbols_q <= 32'd0;
      errors_q  <= 16'd0;
    end else begin
      if (good_evt_s) begin
        symbols_q <= symbols_q + 32'd1;
      end else begin
        symbols_q <= symbols_q;
      end
      if (err_evt_s) begin
        errors_q <= sat_inc16(errors_q);
      end else begin
        errors_q <= errors_q;
      end
    end
  end

  assign stat_symbols = symbols_q;
  assign stat_errors  = errors_q;
`endif

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Directed self-checking bench for ofdm_cp_remover with default parameters
// (DATA_W=22, FFT_LEN=64, CP_LEN=16).
module tb_ofdm_cp_remover;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [21:0] asi_in0_data;
  logic        asi_in0_valid;
  logic        asi_in0_startofpacket;
  logic        asi_in0_endofpacket;
  logic        asi_in0_ready;
  logic [21:0] aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;
  logic [1:0]  aso_out0_error;
  logic        aso_out0_ready;
`ifdef OFDM_CP_REMOVER_STATS_EN
  logic [31:0] stat_symbols;
  logic [15:0] stat_errors;
`endif

  int total = 0;
  int bad   = 0;

  ofdm_cp_remover dut (
    .clk_clk                (clk_clk),
    .reset_reset_n          (reset_reset_n),
    .asi_in0_data           (asi_in0_data),
    .asi_in0_valid          (asi_in0_valid),
    .asi_in0_startofpacket  (asi_in0_startofpacket),
    .asi_in0_endofpacket    (asi_in0_endofpacket),
    .asi_in0_ready          (asi_in0_ready),
    .aso_out0_data          (aso_out0_data),
    .aso_out0_valid         (aso_out0_valid),
    .aso_out0_startofpacket (aso_out0_startofpacket),
    .aso_out0_endofpacket   (aso_out0_endofpacket),
    .aso_out0_error         (aso_out0_error),
    .aso_out0_ready         (aso_out0_ready)
`ifdef OFDM_CP_REMOVER_STATS_EN
    ,
    .stat_symbols           (stat_symbols),
    .stat_errors            (stat_errors)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [21:0] mk(input int id, input int i);
    return 22'(id * 4096 + i);
  endfunction

  // Drive one input beat, then sample just after the clock edge
  task automatic step(input logic [21:0] d, input logic v, input logic s, input logic e);
    asi_in0_data          = d;
    asi_in0_valid         = v;
    asi_in0_startofpacket = s;
    asi_in0_endofpacket   = e;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ev, input logic [21:0] ed,
                     input logic es, input logic ee, input logic [1:0] er);
    total++;
    assert (aso_out0_valid === ev)
      else begin bad++; $error("FAIL %s valid got=%0b exp=%0b", tag, aso_out0_valid, ev); end
    if (ev) begin
      total++;
      assert (aso_out0_data === ed)
        else begin bad++; $error("FAIL %s data got=%0h exp=%0h", tag, aso_out0_data, ed); end
      total++;
      assert (aso_out0_startofpacket === es)
        else begin bad++; $error("FAIL %s sop got=%0b exp=%0b", tag, aso_out0_startofpacket, es); end
      total++;
      assert (aso_out0_endofpacket === ee)
        else begin bad++; $error("FAIL %s eop got=%0b exp=%0b", tag, aso_out0_endofpacket, ee); end
      total++;
      assert (aso_out0_error === er)
        else begin bad++; $error("FAIL %s err got=%0b exp=%0b", tag, aso_out0_error, er); end
    end
  endtask

  // Send one packet with out_ready held high; every beat checked one cycle later
  task automatic send_pkt(input string tag, input int id, input int len, input logic has_eop);
    int         eop_at;
    logic       fw;
    logic       es, ee;
    logic [1:0] er;
    eop_at = has_eop ? len - 1 : 100000;
    for (int i = 0; i < len; i++) begin
      step(mk(id, i), 1'b1, (i == 0), (has_eop && (i == len - 1)));
      fw = (i >= 16) && (i <= 79);
      es = (i == 16);
      ee = (i == 79) || (i == eop_at);
      if ((i == eop_at) && (i < 79)) er = 2'b01;
      else if ((i == 79) && (eop_at > 79)) er = 2'b10;
      else er = 2'b00;
      chk(tag, fw, mk(id, i), es, ee, er);
    end
  endtask

  task automatic chk_stats(input string tag, input int syms, input int errs);
`ifdef OFDM_CP_REMOVER_STATS_EN
    total++;
    assert (stat_symbols === 32'(syms))
      else begin bad++; $error("FAIL %s symbols got=%0d exp=%0d", tag, stat_symbols, syms); end
    total++;
    assert (stat_errors === 16'(errs))
      else begin bad++; $error("FAIL %s errors got=%0d exp=%0d", tag, stat_errors, errs); end
`else
    if (syms < 0 || errs < 0) $display("stats %s not built", tag);
`endif
  endtask

  initial begin
    int         idx, expn, cyc;
    logic       acc, stall, exp_rdy;
    logic [21:0] held;

    reset_reset_n  = 1'b0;
    aso_out0_ready = 1'b1;
    step(22'd0, 1'b0, 1'b0, 1'b0);
    step(22'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    total++;
    assert (aso_out0_data === 22'd0 && aso_out0_startofpacket === 1'b0 &&
            aso_out0_endofpacket === 1'b0 && aso_out0_error === 2'b00)
      else begin bad++; $error("FAIL reset outputs got=%0h/%0b/%0b/%0b exp=0", aso_out0_data,
                               aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_error); end
    chk("reset_valid", 1'b0, 22'd0, 1'b0, 1'b0, 2'b00);
    total++;
    assert (asi_in0_ready === 1'b1)
      else begin bad++; $error("FAIL reset_ready got=%0b exp=1", asi_in0_ready); end
    reset_reset_n = 1'b1;
    step(22'd0, 1'b0, 1'b0, 1'b0);

    // Nominal 80-sample packet
    send_pkt("nominal1", 1, 80, 1'b1);
    step(22'd0, 1'b0, 1'b0, 1'b0);
    chk("idle1", 1'b0, 22'd0, 1'b0, 1'b0, 2'b00);

    // Samples without sop while idle are dropped
    for (int i = 0; i < 3; i++) begin
      step(mk(15, i), 1'b1, 1'b0, 1'b0);
      chk("nosop", 1'b0, 22'd0, 1'b0, 1'b0, 2'b00);
    end

    // Short packet (eop on sample 50) then nominal
    send_pkt("short", 2, 51, 1'b1);
    send_pkt("after_short", 3, 80, 1'b1);

    // Long packet (eop on sample 89) then nominal
    send_pkt("long", 4, 90, 1'b1);
    send_pkt("after_long", 5, 80, 1'b1);

    // Packet ending inside its prefix
    send_pkt("cp_eop", 6, 11, 1'b1);
    step(22'd0, 1'b0, 1'b0, 1'b0);
    chk("cp_eop_idle", 1'b0, 22'd0, 1'b0, 1'b0, 2'b00);
    chk_stats("stats_mid", 3, 3);

    // One-sample packet (sop and eop together)
    step(mk(11, 0), 1'b1, 1'b1, 1'b1);
    chk("one_sample", 1'b0, 22'd0, 1'b0, 1'b0, 2'b00);
    chk_stats("stats_one", 3, 4);

    // Backpressure: random out_ready, stream must be intact and stable on stall
    idx = 0; expn = 16; cyc = 0;
    while ((idx < 80 || expn < 80) && cyc < 2000) begin
      aso_out0_ready        = 1'($urandom_range(0, 1));
      asi_in0_valid         = (idx < 80);
      asi_in0_data          = mk(7, idx);
      asi_in0_startofpacket = (idx == 0);
      asi_in0_endofpacket   = (idx == 79);
      #1;
      exp_rdy = !aso_out0_valid || aso_out0_ready;
      total++;
      assert (asi_in0_ready === exp_rdy)
        else begin bad++; $error("FAIL bp_ready got=%0b exp=%0b", asi_in0_ready, exp_rdy); end
      acc   = asi_in0_valid && asi_in0_ready;
      stall = aso_out0_valid && !aso_out0_ready;
      held  = aso_out0_data;
      if (aso_out0_valid && aso_out0_ready) begin
        chk("bp_out", 1'b1, mk(7, expn), (expn == 16), (expn == 79), 2'b00);
        expn++;
      end
      @(posedge clk_clk);
      #1;
      if (acc) idx++;
      if (stall) begin
        total++;
        assert (aso_out0_valid === 1'b1 && aso_out0_data === held)
          else begin bad++; $error("FAIL bp_hold got=%0h exp=%0h", aso_out0_data, held); end
      end
      cyc++;
    end
    total++;
    assert (cyc < 2000)
      else begin bad++; $error("FAIL bp_timeout got=%0d exp=80", expn); end
    aso_out0_ready = 1'b1;
    step(22'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_idle", 1'b0, 22'd0, 1'b0, 1'b0, 2'b00);
    chk_stats("stats_bp", 4, 4);

    // Reset in the middle of a packet (after sample 40 forwarded)
    send_pkt("pre_reset", 8, 41, 1'b0);
    asi_in0_valid = 1'b0;
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 22'd0, 1'b0, 1'b0, 2'b00);
    total++;
    assert (aso_out0_data === 22'd0 && aso_out0_endofpacket === 1'b0 && aso_out0_error === 2'b00)
      else begin bad++; $error("FAIL async_reset_regs got=%0h exp=0", aso_out0_data); end
    chk_stats("stats_reset", 0, 0);
    step(22'd0, 1'b0, 1'b0, 1'b0);
    reset_reset_n = 1'b1;
    step(22'd0, 1'b0, 1'b0, 1'b0);
    send_pkt("after_reset", 9, 80, 1'b1);
    step(22'd0, 1'b0, 1'b0, 1'b0);
    chk_stats("stats_end", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ofdm_cp_remover.md
OFDM_CP_REMOVER -- requirements
Module: ofdm_cp_remover

Interface
REQ-001 SHALL have parameter DATA_W, default 22, sample width (11-bit I, 11-bit Q packed).
REQ-002 SHALL have parameter FFT_LEN, default 64, useful samples per OFDM symbol, range 8..1024.
REQ-003 SHALL have parameter CP_LEN, default 16, cyclic-prefix samples per symbol, range 1..FFT_LEN-1.
REQ-004 SHALL have port clk_clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port asi_in0_data, input, DATA_W, received sample.
REQ-007 SHALL have port asi_in0_valid, input, 1, sample qualifier.
REQ-008 SHALL have port asi_in0_startofpacket, input, 1, first sample of CP+symbol.
REQ-009 SHALL have port asi_in0_endofpacket, input, 1, last sample of CP+symbol.
REQ-010 SHALL have port asi_in0_ready, output, 1, sink ready (readyLatency 0).
REQ-011 SHALL have port aso_out0_data, output, DATA_W, useful-part sample.
REQ-012 SHALL have port aso_out0_valid, output, 1, output qualifier.
REQ-013 SHALL have port aso_out0_startofpacket and aso_out0_endofpacket, output, 1 each, symbol framing.
REQ-014 SHALL have port aso_out0_error, output, 2, bit0 short packet, bit1 long packet; valid with endofpacket only.
REQ-015 SHALL have port aso_out0_ready, input, 1, downstream ready.

Function
REQ-016 SHALL strip the first CP_LEN accepted samples of each packet and forward the next FFT_LEN samples unchanged.
REQ-017 SHALL accept input only when asi_in0_valid && asi_in0_ready; asi_in0_ready = !aso_out0_valid || aso_out0_ready.
REQ-018 SHALL register output: accepted forwarded sample appears on aso_out0_* exactly 1 cycle later; held stable while aso_out0_valid && !aso_out0_ready.
REQ-019 SHALL implement states IDLE, CP, BODY, FLUSH, with a shared sample counter of width clog2(FFT_LEN).
REQ-020 SHALL in IDLE drop samples without sop; sop accepted -> CP (counter=1), or BODY if CP_LEN==1.
REQ-021 SHALL in CP drop samples; counter reaching CP_LEN -> BODY with counter cleared.
REQ-022 SHALL in BODY forward samples; first forwarded sample carries out sop; FFT_LEN-th carries out eop -> IDLE.
REQ-023 SHALL on input eop in CP: drop sample, no output, -> IDLE, increment error count (REQ-033).
REQ-024 SHALL on input eop in BODY before FFT_LEN-th sample: forward it with out eop, error=2'b01 -> IDLE.
REQ-025 SHALL on FFT_LEN-th BODY sample without input eop: forward with forced out eop, error=2'b10 -> FLUSH.
REQ-026 SHALL in FLUSH drop samples until an accepted eop -> IDLE; accepted sop in FLUSH restarts as REQ-020.
REQ-027 SHALL on sop in CP or BODY (missing eop): close any open output symbol is not required; restart counting from that sop; if in BODY, error bit1 is reported on next out eop of that aborted symbol only if already emitted, otherwise no marker.
REQ-028 SHALL treat simultaneous sop and eop on one sample as a 1-sample packet: short-packet path (REQ-023).
REQ-029 SHALL drive aso_out0_error=2'b00 on every correctly framed symbol.

Reset
REQ-030 SHALL on reset_reset_n low asynchronously force state IDLE, counter 0, aso_out0_valid/sop/eop 0, aso_out0_error 0, aso_out0_data 0.
REQ-031 SHALL discard any partially received symbol on reset; first sop after release starts cleanly.

Configuration
REQ-032 SHALL compile statistics logic only when OFDM_CP_REMOVER_STATS_EN is defined.
REQ-033 SHALL with OFDM_CP_REMOVER_STATS_EN add outputs stat_symbols (32-bit, good symbols) and stat_errors (16-bit, saturating, short+long+CP-eop events), cleared by reset; without it, ports absent and no counters.

Structure
REQ-034 SHALL place state enum and error-bit constants (ERR_SHORT=0, ERR_LONG=1) in shared package ofdm_pkg.
REQ-035 SHALL be a single module; output register stage is inline, no sub-module.

Verification
REQ-036 SHALL cover nominal: 80-sample packet, samples 0..79, out_ready=1 -> 64 outputs 16..79, sop on 16, eop on 79, error 0, latency 1.
REQ-037 SHALL cover backpressure: out_ready toggled 50% random -> identical output sequence, no loss/duplication, data stable while stalled.
REQ-038 SHALL cover short packet: eop on sample 50 -> outputs 16..50, eop on 50, error 2'b01; next packet nominal.
REQ-039 SHALL cover long packet: 90 samples, eop on 89 -> 64 outputs, eop on 79 error 2'b10, samples 80..89 dropped.
REQ-040 SHALL cover CP eop: eop on sample 10 -> no output; with STATS_EN stat_errors=1.
REQ-041 SHALL cover reset at sample 40 of a packet -> outputs idle immediately; next packet nominal.
